// File: rtl/iter_shifter_pkg.sv
// shifter_pkg: mode codes, FSM state encoding and width helper shared by the iter_shifter slice.
package shifter_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic int amt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/result handshake bundle between the control unit (master) and iter_shifter (slave).
interface iter_shifter_if #(
    parameter int WIDTH = 32
) ();
    localparam int AMTW = shifter_pkg::amt_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMTW-1:0]  in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// shift_step: one combinational shift by k in SLL/SRL/SRA (and ROL when SHIFTER_ROTATE_EN is defined).
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMTW  = 5
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic [AMTW-1:0]  k_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] d_o,
    output logic             carry_o
);
    logic [AMTW-1:0]  lidx;
    logic [AMTW-1:0]  ridx;
    logic [WIDTH-1:0] sra;

    always_comb begin
        lidx = AMTW'(WIDTH - int'(k_i));
        ridx = k_i - AMTW'(1);
        sra  = $signed(d_i) >>> k_i;
        d_o  = mode_i == MODE_SRL ? d_i >> k_i : mode_i == MODE_SRA ? sra : d_i << k_i;
`ifdef SHIFTER_ROTATE_EN
        // lidx wraps to 0 when k is 0, so the OR degenerates to d_i itself
        if (mode_i == MODE_ROL) d_o = (d_i << k_i) | (d_i >> lidx);
`endif
        carry_o = k_i == '0 ? 1'b0 : (mode_i == MODE_SRL || mode_i == MODE_SRA) ? d_i[ridx] : d_i[lidx];
    end
endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter moving up to STEP bits per clock behind valid/ready handshakes.
// Rotate-left on mode 11 only when SHIFTER_ROTATE_EN is defined; otherwise mode 11 acts as SLL.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input logic          clk,
    input logic          rst,
    iter_shifter_if.slave bus
);
    localparam int AMTW = amt_width(WIDTH);
    localparam logic [AMTW-1:0] STEP_W = AMTW'(STEP);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, step_data;
    logic [AMTW-1:0]  rem_q, rem_d, k;
    logic [1:0]       mode_q, mode_d;
    logic             carry_q, carry_d, step_carry;

    assign k = rem_q > STEP_W ? STEP_W : rem_q;

    shift_step #(.WIDTH(WIDTH), .AMTW(AMTW)) u_step (
        .d_i     (data_q),
        .k_i     (k),
        .mode_i  (mode_q),
        .d_o     (step_data),
        .carry_o (step_carry)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        if (state_q == IDLE && bus.in_valid) begin
            data_d  = bus.in_data;
            mode_d  = bus.in_mode;
            rem_d   = bus.in_amt;
            carry_d = 1'b0;
            state_d = bus.in_amt == '0 ? DONE : SHIFT;
        end else if (state_q == SHIFT) begin
            data_d  = step_data;
            carry_d = step_carry;
            rem_d   = rem_q - k;
            state_d = rem_q == k ? DONE : SHIFT;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_SLL;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_data  = data_q;
    assign bus.out_carry = carry_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed checks of iter_shifter at WIDTH=32, STEP=4; ROL expectation follows SHIFTER_ROTATE_EN.
module tb_iter_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    iter_shifter_if #(.WIDTH(32)) bus ();

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Issue one request, then wait (bounded) for out_valid; leaves the result pending in DONE.
    task automatic issue(input string tag, input logic [31:0] d, input logic [4:0] amt, input logic [1:0] mode,
                         input logic [31:0] exp_d, input logic exp_c, input int exp_lat);
        int lat;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = amt;
        bus.in_mode  = mode;
        @(posedge clk);
        lat = 1;
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_amt   = 5'($urandom);
        bus.in_mode  = 2'($urandom);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, bus.out_data, exp_d);
        chk({tag, "_carry"}, 32'(bus.out_carry), 32'(exp_c));
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_carry", 32'(bus.out_carry), 32'd0);

        issue("sll1", 32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002, 1'b0, 2);
        release_out("sll1");
        issue("sll1c", 32'h8000_0001, 5'd1, 2'b00, 32'h0000_0002, 1'b1, 2);
        release_out("sll1c");
        issue("sra31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0, 9);
        release_out("sra31");
        issue("srl4", 32'hF000_000F, 5'd4, 2'b01, 32'h0F00_0000, 1'b1, 2);
        release_out("srl4");
        issue("amt0", 32'h1234_5678, 5'd0, 2'b10, 32'h1234_5678, 1'b0, 1);
        release_out("amt0");
`ifdef SHIFTER_ROTATE_EN
        issue("rol4", 32'h8000_0001, 5'd4, 2'b11, 32'h0000_0018, 1'b0, 2);
`else
        issue("rol4", 32'h8000_0001, 5'd4, 2'b11, 32'h0000_0010, 1'b0, 2);
`endif
        release_out("rol4");

        // backpressure: result must hold while a second request is ignored
        issue("bp", 32'h0000_0003, 5'd5, 2'b00, 32'h0000_0060, 1'b0, 3);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_amt   = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", bus.out_data, 32'h0000_0060);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_out("bp");
        chk("bp_not_queued", 32'(bus.out_valid), 32'd0);

        // reset in the middle of a 20-bit shift
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        bus.in_amt   = 5'd20;
        bus.in_mode  = 2'b00;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_out_data", bus.out_data, 32'd0);
        chk("mrst_out_carry", 32'(bus.out_carry), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("mrst_no_result", 32'(bus.out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
